// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level game-flow controller for the dinosaur game. Steps the game
//   through idle, run, hit and game-over phases, gates the object updaters,
//   scans the gamedata bus once per tick for player/obstacle collisions, and
//   keeps score and speed level for display.
//
// Ports
//   clock      system clock
//   rst        synchronous active-high reset
//   tick       one-clock game-frame pulse
//   jump       player button, already synchronised to clock
//   gamedata   packed object state, slot k at [k*DATALEN +: DATALEN]
//              ([7:0] x, [14:8] y, [15] active; slot 0 = player)
//   run_en     object updaters advance only when 1
//   clear      one-cycle pulse returning objects to start positions
//   hit_flash  toggles on each tick while in HIT
//   game_over  high while in OVER
//   score      current score, saturating at SCORE_MAX
//   speed      speed level 0..3
//   overrun    sticky: a tick arrived while a scan was still running
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the first jump after reset
// S_START | one cycle: clear objects, zero score/speed/overrun
// S_RUN   | game running, score counts ticks, collision scan active
// S_HIT   | collision flash for HIT_TICKS ticks, score frozen
// S_OVER  | game over; jump restarts only after OVER_LOCK ticks
module game_sequencer #(
    parameter int DATALEN    = 16,
    parameter int DATACOUNT  = 10,
    parameter int HIT_W      = 6,
    parameter int HIT_H      = 8,
    parameter int HIT_TICKS  = 16,
    parameter int OVER_LOCK  = 32,
    parameter int SPEED_STEP = 100,
    parameter int SCORE_MAX  = 9999
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          jump,
    input  logic [DATALEN*DATACOUNT-1:0]  gamedata,
    output logic                          run_en,
    output logic                          clear,
    output logic                          hit_flash,
    output logic                          game_over,
    output logic [13:0]                   score,
    output logic [1:0]                    speed,
    output logic                          overrun
);

    localparam int IDX_W   = $clog2(DATACOUNT);
    localparam int SPD_W   = $clog2(SPEED_STEP);
    localparam int TCK_MAX = (HIT_TICKS > OVER_LOCK) ? HIT_TICKS : OVER_LOCK;
    localparam int TCK_W   = $clog2(TCK_MAX + 1);

    localparam logic [IDX_W-1:0] FIRST_SLOT = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_SLOT  = IDX_W'(DATACOUNT - 1);
    localparam logic [13:0]      SCORE_TOP  = 14'(SCORE_MAX);
    localparam logic [SPD_W-1:0] SPD_RELOAD = SPD_W'(SPEED_STEP - 1);
    localparam logic [TCK_W-1:0] HIT_LOAD   = TCK_W'(HIT_TICKS);
    localparam logic [TCK_W-1:0] OVER_LOAD  = TCK_W'(OVER_LOCK);
    localparam logic [TCK_W-1:0] TCK_ONE    = TCK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HIT,
        S_OVER
    } state_t;

    state_t             state, state_next;
    logic               jump_q;
    logic               jump_rise;
    logic               scan_busy, scan_busy_next;
    logic [IDX_W-1:0]   scan_idx, scan_idx_next;
    logic [TCK_W-1:0]   tick_cnt, tick_cnt_next;
    logic [SPD_W-1:0]   speed_cnt, speed_cnt_next;
    logic [13:0]        score_next;
    logic [1:0]         speed_next;
    logic               overrun_next;
    logic               run_en_next, clear_next, hit_flash_next, game_over_next;
    logic               score_inc;

    logic [DATALEN-1:0] slot_arr [DATACOUNT];
    logic [DATALEN-1:0] slot;
    logic [8:0]         px, py, ex, ey, dx, dy;
    logic               slot_hit;

    genvar k;
    generate
        for (k = 0; k < DATACOUNT; k++) begin : g_slot
            assign slot_arr[k] = gamedata[k*DATALEN +: DATALEN];
        end
    endgenerate

    assign jump_rise = jump & ~jump_q;

    // Magnitudes are taken at 9 bits so an obstacle near x=255 never
    // aliases onto a player near x=0.
    always_comb begin
        slot     = slot_arr[scan_idx];
        px       = {1'b0, slot_arr[0][7:0]};
        py       = {2'b00, slot_arr[0][14:8]};
        ex       = {1'b0, slot[7:0]};
        ey       = {2'b00, slot[14:8]};
        dx       = (px >= ex) ? (px - ex) : (ex - px);
        dy       = (py >= ey) ? (py - ey) : (ey - py);
        slot_hit = scan_busy && slot[15] && (dx < 9'(HIT_W)) && (dy < 9'(HIT_H));
    end

    always_comb begin
        state_next     = state;
        scan_busy_next = scan_busy;
        scan_idx_next  = scan_idx;
        tick_cnt_next  = tick_cnt;
        score_next     = score;
        speed_next     = speed;
        speed_cnt_next = speed_cnt;
        overrun_next   = overrun;
        hit_flash_next = 1'b0;
        score_inc      = 1'b0;

        case (state)
            S_IDLE: begin
                if (jump_rise) state_next = S_START;
            end
            S_START: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (scan_busy) begin
                    if (scan_idx == LAST_SLOT) scan_busy_next = 1'b0;
                    else                       scan_idx_next  = scan_idx + FIRST_SLOT;
                end
                // A new tick always restarts the scan from the first obstacle.
                if (tick) begin
                    score_inc      = 1'b1;
                    scan_busy_next = 1'b1;
                    scan_idx_next  = FIRST_SLOT;
                    if (scan_busy) overrun_next = 1'b1;
                end
                // Hit takes priority over the restart; the tick's score still counts.
                if (slot_hit) begin
                    state_next     = S_HIT;
                    scan_busy_next = 1'b0;
                    tick_cnt_next  = HIT_LOAD;
                end
            end
            S_HIT: begin
                hit_flash_next = hit_flash;
                if (tick) begin
                    if (tick_cnt == TCK_ONE) begin
                        state_next     = S_OVER;
                        tick_cnt_next  = OVER_LOAD;
                        hit_flash_next = 1'b0;
                    end else begin
                        tick_cnt_next  = tick_cnt - TCK_ONE;
                        hit_flash_next = ~hit_flash;
                    end
                end
            end
            S_OVER: begin
                if (jump_rise && (tick_cnt == '0)) begin
                    state_next = S_START;
                end else if (tick && (tick_cnt != '0)) begin
                    tick_cnt_next = tick_cnt - TCK_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Speed level advances every SPEED_STEP score points via a reload counter.
        if (score_inc && (score != SCORE_TOP)) begin
            score_next = score + 14'd1;
            if (speed_cnt == '0) begin
                speed_cnt_next = SPD_RELOAD;
                if (speed != 2'd3) speed_next = speed + 2'd1;
            end else begin
                speed_cnt_next = speed_cnt - SPD_W'(1);
            end
        end

        // New game: applied on entry so score reads 0 alongside clear.
        if (state_next == S_START) begin
            score_next     = '0;
            speed_next     = '0;
            speed_cnt_next = SPD_RELOAD;
            overrun_next   = 1'b0;
            scan_busy_next = 1'b0;
            scan_idx_next  = FIRST_SLOT;
        end

        run_en_next    = (state_next == S_RUN);
        clear_next     = (state_next == S_START);
        game_over_next = (state_next == S_OVER);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= S_IDLE;
            jump_q    <= 1'b0;
            scan_busy <= 1'b0;
            scan_idx  <= '0;
            tick_cnt  <= '0;
            speed_cnt <= '0;
            score     <= '0;
            speed     <= '0;
            overrun   <= 1'b0;
            run_en    <= 1'b0;
            clear     <= 1'b0;
            hit_flash <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            jump_q    <= jump;
            scan_busy <= scan_busy_next;
            scan_idx  <= scan_idx_next;
            tick_cnt  <= tick_cnt_next;
            speed_cnt <= speed_cnt_next;
            score     <= score_next;
            speed     <= speed_next;
            overrun   <= overrun_next;
            run_en    <= run_en_next;
            clear     <= clear_next;
            hit_flash <= hit_flash_next;
            game_over <= game_over_next;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Directed bench for game_sequencer: collision-window vectors from a table,
//   plus hand-written sequences for start, long run, hit/over timing,
//   overrun and score saturation / reset.
module tb_game_sequencer;

    localparam int DATALEN   = 16;
    localparam int DATACOUNT = 10;

    logic                         clock = 1'b0;
    logic                         rst   = 1'b1;
    logic                         tick  = 1'b0;
    logic                         jump  = 1'b0;
    logic [DATALEN*DATACOUNT-1:0] gd    = '0;
    logic                         run_en, clear, hit_flash, game_over, overrun;
    logic [13:0]                  score;
    logic [1:0]                   speed;

    int checks = 0;
    int errors = 0;

    game_sequencer dut (
        .clock     (clock),
        .rst       (rst),
        .tick      (tick),
        .jump      (jump),
        .gamedata  (gd),
        .run_en    (run_en),
        .clear     (clear),
        .hit_flash (hit_flash),
        .game_over (game_over),
        .score     (score),
        .speed     (speed),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         slot;
        logic [7:0] px;
        logic [6:0] py;
        logic       act;
        logic [7:0] ex;
        logic [6:0] ey;
        logic       exp_hit;
    } vec_t;

    vec_t vecs [13];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic a, input logic [7:0] x, input logic [6:0] y);
        gd[k*DATALEN +: DATALEN] = {a, y, x};
    endtask

    task automatic start_game();
        rst  = 1'b1;
        tick = 1'b0;
        jump = 1'b0;
        cyc(1);
        rst  = 1'b0;
        jump = 1'b1;
        cyc(1);
        jump = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        int clears;

        // slot, player x/y, obstacle active/x/y, hit expected
        vecs[0]  = '{4, 8'd20,  7'd40,  1'b1, 8'd25,  7'd45,  1'b1};
        vecs[1]  = '{4, 8'd20,  7'd40,  1'b1, 8'd26,  7'd45,  1'b0};
        vecs[2]  = '{1, 8'd20,  7'd40,  1'b1, 8'd15,  7'd40,  1'b1};
        vecs[3]  = '{1, 8'd20,  7'd40,  1'b1, 8'd14,  7'd40,  1'b0};
        vecs[4]  = '{9, 8'd20,  7'd40,  1'b1, 8'd20,  7'd47,  1'b1};
        vecs[5]  = '{9, 8'd20,  7'd40,  1'b1, 8'd20,  7'd48,  1'b0};
        vecs[6]  = '{5, 8'd20,  7'd40,  1'b1, 8'd20,  7'd33,  1'b1};
        vecs[7]  = '{5, 8'd20,  7'd40,  1'b1, 8'd20,  7'd32,  1'b0};
        vecs[8]  = '{3, 8'd20,  7'd40,  1'b0, 8'd20,  7'd40,  1'b0};
        vecs[9]  = '{2, 8'd2,   7'd40,  1'b1, 8'd253, 7'd40,  1'b0};
        vecs[10] = '{7, 8'd20,  7'd2,   1'b1, 8'd20,  7'd126, 1'b0};
        vecs[11] = '{6, 8'd250, 7'd120, 1'b1, 8'd255, 7'd127, 1'b1};
        vecs[12] = '{8, 8'd0,   7'd0,   1'b1, 8'd5,   7'd7,   1'b1};

        // Reset state; ticks in IDLE change nothing
        cyc(2);
        chk("rst_run_en", run_en, 0);
        chk("rst_clear", clear, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_score", score, 0);
        rst = 1'b0;
        ticks(3);
        chk("idle_tick_score", score, 0);
        chk("idle_tick_run_en", run_en, 0);

        // Jump held 5 cycles: one clear, then RUN; second rise in RUN ignored
        jump   = 1'b1;
        clears = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (clear) clears++;
            if (i == 0) begin
                chk("start_clear", clear, 1);
                chk("start_run_en", run_en, 0);
            end
            if (i == 1) chk("run_after_start", run_en, 1);
        end
        jump = 1'b0;
        chk("single_clear", clears, 1);
        cyc(1);
        jump = 1'b1;
        cyc(1);
        chk("rejump_clear", clear, 0);
        chk("rejump_run_en", run_en, 1);
        jump = 1'b0;

        // Collision window vectors
        for (int i = 0; i < 13; i++) begin
            gd = '0;
            set_slot(0, 1'b0, vecs[i].px, vecs[i].py);
            set_slot(vecs[i].slot, vecs[i].act, vecs[i].ex, vecs[i].ey);
            start_game();
            do_tick();
            cyc(DATACOUNT - 1);
            chk($sformatf("vec%0d_run_en", i), run_en, {31'd0, ~vecs[i].exp_hit});
            chk($sformatf("vec%0d_score", i), score, 1);
        end

        // Long run, no obstacles: 250 well-spaced ticks
        gd = '0;
        start_game();
        for (int i = 0; i < 250; i++) begin
            do_tick();
            cyc(9);
        end
        chk("run250_score", score, 250);
        chk("run250_speed", speed, 2);
        chk("run250_game_over", game_over, 0);
        chk("run250_overrun", overrun, 0);
        chk("run250_run_en", run_en, 1);

        // Hit -> flash 16 ticks -> OVER; lockout boundary at 31/32 ticks
        gd = '0;
        set_slot(0, 1'b1, 8'd20, 7'd40);
        set_slot(4, 1'b1, 8'd25, 7'd45);
        start_game();
        do_tick();
        cyc(DATACOUNT - 1);
        chk("hit_run_en", run_en, 0);
        for (int j = 1; j <= 16; j++) begin
            do_tick();
            chk($sformatf("flash_t%0d", j), hit_flash, (j < 16) ? (j % 2) : 0);
            chk($sformatf("over_t%0d", j), game_over, (j == 16) ? 1 : 0);
        end
        chk("hit_score_frozen", score, 1);
        ticks(10);
        jump = 1'b1;
        cyc(1);
        jump = 1'b0;
        chk("lock10_clear", clear, 0);
        chk("lock10_over", game_over, 1);
        cyc(1);
        ticks(21);
        jump = 1'b1;
        cyc(1);
        jump = 1'b0;
        chk("lock31_clear", clear, 0);
        cyc(1);
        do_tick();
        jump = 1'b1;
        cyc(1);
        jump = 1'b0;
        chk("unlock_clear", clear, 1);
        chk("unlock_score", score, 0);
        chk("unlock_game_over", game_over, 0);
        cyc(1);
        chk("unlock_run_en", run_en, 1);
        chk("unlock_clear_drop", clear, 0);

        // Overrun: ticks every 4 cycles keep restarting the scan before slot 9
        gd = '0;
        set_slot(0, 1'b1, 8'd20, 7'd40);
        set_slot(9, 1'b1, 8'd20, 7'd40);
        start_game();
        for (int i = 1; i <= 6; i++) begin
            do_tick();
            chk($sformatf("ovr_t%0d", i), overrun, (i >= 2) ? 1 : 0);
            cyc(3);
        end
        chk("ovr_score", score, 6);
        chk("ovr_no_hit_yet", run_en, 1);
        cyc(5);
        chk("ovr_scan_pre", run_en, 1);
        cyc(1);
        chk("ovr_scan_hit", run_en, 0);
        chk("ovr_sticky", overrun, 1);
        ticks(16 + 32);
        chk("ovr_over", game_over, 1);
        chk("ovr_score_held", score, 6);
        jump = 1'b1;
        cyc(1);
        jump = 1'b0;
        chk("ovr_restart_clear", clear, 1);
        chk("ovr_cleared", overrun, 0);

        // Score saturation, then reset mid-HIT
        gd = '0;
        start_game();
        tick = 1'b1;
        cyc(9998);
        chk("sat_9998", score, 9998);
        cyc(3);
        tick = 1'b0;
        chk("sat_9999", score, 9999);
        chk("sat_speed", speed, 3);
        chk("sat_overrun", overrun, 1);
        cyc(1);
        set_slot(1, 1'b1, 8'd0, 7'd0);
        do_tick();
        cyc(1);
        chk("sat_hit_run_en", run_en, 0);
        chk("sat_hit_score", score, 9999);
        do_tick();
        chk("sat_flash", hit_flash, 1);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_run_en", run_en, 0);
        chk("mid_rst_flash", hit_flash, 0);
        chk("mid_rst_over", game_over, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_speed", speed, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_clear", clear, 0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_run_en", run_en, 0);
        // tick and jump together in IDLE: jump wins, tick counts nothing
        tick = 1'b1;
        jump = 1'b1;
        cyc(1);
        tick = 1'b0;
        jump = 1'b0;
        chk("idle_tj_clear", clear, 1);
        cyc(1);
        chk("idle_tj_run_en", run_en, 1);
        chk("idle_tj_score", score, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the dinosaur game.
- Sequences the game through idle, run, hit and game-over phases, and gates the frame-rate object updaters (player and enemy) via run_en.
- Scans the shared gamedata bus once per game tick for player/obstacle collisions.
- Maintains score and speed level for display, and issues a clear pulse that re-initialises objects on each new game.

Parameters:
DATALEN, 16, bits per gamedata slot: [7:0] x, [14:8] y, [15] active
DATACOUNT, 10, number of slots; slot 0 = player, slots 1..DATACOUNT-1 = obstacles
HIT_W, 6, horizontal collision half-window in pixels
HIT_H, 8, vertical collision half-window in pixels
HIT_TICKS, 16, ticks spent in HIT before OVER
OVER_LOCK, 32, ticks in OVER before jump may restart
SPEED_STEP, 100, score points per speed level increment
SCORE_MAX, 9999, score saturation value

Ports:
clock  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-clock game-frame pulse, synchronous to clock
jump  in  1  player button, already synchronised to clock
gamedata  in  DATALEN*DATACOUNT  packed object state, slot k at [k*DATALEN +: DATALEN]
run_en  out  1  object updaters advance only when 1
clear  out  1  one-cycle pulse: objects return to start positions
hit_flash  out  1  toggles each tick in HIT, else 0
game_over  out  1  high in OVER
score  out  14  current score, binary
speed  out  2  speed level 0..3
overrun  out  1  sticky: a tick arrived while a scan was in progress

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state=IDLE.
  - All outputs 0; score=0, speed=0, overrun=0.
  - Scan engine idle; jump edge register=0; tick counters=0.
  - Reset mid-game aborts the game immediately.
- jump_rise = jump & ~jump_q, where jump_q is registered every cycle.
- States and transitions:
  - IDLE: run_en=0. On jump_rise -> START.
  - START (exactly 1 cycle):
    - clear=1, run_en=0.
    - score<=0, speed<=0, overrun<=0, scan aborted.
    - Next cycle -> RUN.
  - RUN: run_en=1.
    - Each tick: score<=min(score+1, SCORE_MAX); start scan at slot 1.
    - speed<=min(score_new/SPEED_STEP, 3). Compute via a counter reset each SPEED_STEP, not a divider.
  - Scan engine (RUN only):
    - Checks one obstacle slot per clock, slots 1..DATACOUNT-1; scan latency is DATACOUNT-1 cycles after tick.
    - A hit requires all of: slot active=1, |px-ex|<HIT_W, |py-ey|<HIT_H.
    - Differences are unsigned magnitudes computed at 9 bits, no wrap.
    - Player active bit is ignored.
    - A hit ends the scan; state -> HIT on the next cycle. run_en drops that cycle.
    - A tick arriving while a scan is busy restarts the scan at slot 1, sets overrun=1, and still increments score.
  - HIT: run_en=0.
    - hit_flash toggles on each tick.
    - After HIT_TICKS ticks -> OVER with hit_flash=0.
    - Score and speed are frozen.
  - OVER: game_over=1, run_en=0, score held.
    - jump_rise is ignored until OVER_LOCK ticks have elapsed in OVER.
    - After that, jump_rise -> START, and game_over drops in START.
- Simultaneous events:
  - tick and jump_rise in the same cycle in IDLE/OVER: the jump is handled first, and the tick counts toward nothing.
  - A hit found on the same cycle as a new tick in RUN: the hit wins, and the score increment from that tick is still applied.
- Score saturates at SCORE_MAX; speed saturates at 3.
- All outputs are registered. clear is never high for more than 1 cycle.

Test Plan:
1. Reset, then jump held high for 5 cycles -> exactly one clear pulse, 1 cycle after the rising edge; run_en=1 the following cycle; a second jump_rise in RUN has no effect.
2. RUN with all obstacles inactive, 250 ticks -> score=250, speed=2, game_over=0, overrun=0.
3. Player (x=20, y=40); slot 4 active at (x=25, y=45) -> HIT within DATACOUNT cycles of the next tick, run_en=0. Moving the obstacle to x=26 -> no hit (boundary of HIT_W=6).
4. Hit occurs -> hit_flash toggles 16 times, then game_over=1. A jump at 10 ticks into OVER is ignored; a jump after 32 ticks gives clear and score=0.
5. Ticks spaced 4 cycles apart (shorter than the 9-cycle scan) -> overrun=1 sticky, scan restarts, score still counts every tick; overrun is cleared by START.
6. Preload score to 9998 via ticks, apply 3 more ticks -> score=9999 held; assert rst mid-HIT -> all outputs 0, state IDLE next cycle.
